// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory
// port and fills the IF/ID pipeline register, with a one-word skid for stalls and
// a drain state that retires an abandoned request after a redirect.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instruction,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2
);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam logic [15:0] ResetPcAligned = {RESET_PC[15:1], 1'b0};

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] skid_q, skid_d;
  logic [15:0] drain_addr_q, drain_addr_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic [15:0] ifpc2_q, ifpc2_d;

  logic        accept;
  logic [15:0] pc_plus2;
  logic [15:0] redirect_target;

  assign accept          = !valid_q || !stall;
  assign pc_plus2        = pc_q + 16'd2;
  assign redirect_target = {redirect_pc[15:1], 1'b0};

  // Memory request: only one request is ever in flight; HOLD issues nothing
  // because the skid register is already full.
  always_comb begin
    imem_read    = 1'b0;
    imem_address = pc_q;
    if (!reset) begin
      unique case (state_q)
        StFetch: imem_read = 1'b1;
        StDrain: begin
          imem_read    = 1'b1;
          imem_address = drain_addr_q;
        end
        default: imem_read = 1'b0;
      endcase
    end
  end

  // Next-state logic; redirect overrides stall and response in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_d       = skid_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    ifpc2_d      = ifpc2_q;

    if (redirect) begin
      valid_d = 1'b0;
      pc_d    = redirect_target;
      unique case (state_q)
        StFetch: begin
          if (!imem_resp) begin
            // Request still in flight at the old pc; must retire it first.
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end
        end
        StHold:  state_d = StFetch;
        StDrain: if (imem_resp) state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_resp && accept) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            ifpc2_d = pc_plus2;
            pc_d    = pc_plus2;
          end else if (imem_resp) begin
            skid_d  = imem_rdata;
            state_d = StHold;
          end else if (accept) begin
            valid_d = 1'b0;
          end
        end
        StHold: begin
          if (accept) begin
            valid_d = 1'b1;
            instr_d = skid_q;
            ifpc_d  = pc_q;
            ifpc2_d = pc_plus2;
            pc_d    = pc_plus2;
            state_d = StFetch;
          end
        end
        StDrain: begin
          valid_d = 1'b0;
          if (imem_resp) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State registers with synchronous reset; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= ResetPcAligned;
      skid_q       <= 16'h0000;
      drain_addr_q <= 16'h0000;
      valid_q      <= 1'b0;
      instr_q      <= 16'h0000;
      ifpc_q       <= 16'h0000;
      ifpc2_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_q       <= skid_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      ifpc2_q      <= ifpc2_d;
    end
  end

  assign if_valid       = valid_q;
  assign if_instruction = instr_q;
  assign if_pc          = ifpc_q;
  assign if_pc_plus2    = ifpc2_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: linear stimulus, immediate assertions.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instruction;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_resp = 1'b1; imem_rdata = 16'hEEEE;
    step(); step();
    // Reset state
    chk("rst_read",   {15'd0, imem_read}, 16'd0);
    chk("rst_valid",  {15'd0, if_valid}, 16'd0);
    chk("rst_instr",  if_instruction, 16'h0000);
    chk("rst_pc",     if_pc, 16'h0000);
    chk("rst_pc2",    if_pc_plus2, 16'h0000);

    // Zero-wait stream
    reset = 1'b0; imem_rdata = 16'h1001;
    #1;
    chk("first_read", {15'd0, imem_read}, 16'd1);
    chk("first_addr", imem_address, 16'h0000);
    step();
    chk("s0_valid", {15'd0, if_valid}, 16'd1);
    chk("s0_instr", if_instruction, 16'h1001);
    chk("s0_pc",    if_pc, 16'h0000);
    chk("s0_pc2",   if_pc_plus2, 16'h0002);
    imem_rdata = 16'h1002;
    step();
    chk("s1_instr", if_instruction, 16'h1002);
    chk("s1_pc",    if_pc, 16'h0002);
    imem_rdata = 16'h1003;
    step();
    chk("s2_instr", if_instruction, 16'h1003);
    chk("s2_pc",    if_pc, 16'h0004);
    chk("s2_pc2",   if_pc_plus2, 16'h0006);
    chk("s2_addr",  imem_address, 16'h0006);

    // Stall with response -> HOLD
    stall = 1'b1; imem_rdata = 16'hABCD;
    step();
    chk("hold_read",  {15'd0, imem_read}, 16'd0);
    chk("hold_instr", if_instruction, 16'h1003);
    chk("hold_pc",    if_pc, 16'h0004);
    imem_resp = 1'b0;
    step();
    chk("hold2_read",  {15'd0, imem_read}, 16'd0);
    chk("hold2_instr", if_instruction, 16'h1003);
    stall = 1'b0;
    step();
    chk("unhold_valid", {15'd0, if_valid}, 16'd1);
    chk("unhold_instr", if_instruction, 16'hABCD);
    chk("unhold_pc",    if_pc, 16'h0006);
    chk("unhold_read",  {15'd0, imem_read}, 16'd1);
    chk("unhold_addr",  imem_address, 16'h0008);

    // Advance pc to 0x0010
    imem_resp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 16'h2000 + 16'(i);
      step();
    end
    chk("adv_pc",   if_pc, 16'h000E);
    chk("adv_addr", imem_address, 16'h0010);
    imem_resp = 1'b0;
    step();
    chk("bubble_valid", {15'd0, if_valid}, 16'd0);
    chk("bubble_addr",  imem_address, 16'h0010);

    // Redirect with request outstanding -> DRAIN
    redirect = 1'b1; redirect_pc = 16'h3001;
    step();
    redirect = 1'b0;
    chk("drain_valid", {15'd0, if_valid}, 16'd0);
    chk("drain_read",  {15'd0, imem_read}, 16'd1);
    chk("drain_addr",  imem_address, 16'h0010);
    step();
    chk("drain2_addr", imem_address, 16'h0010);
    imem_resp = 1'b1; imem_rdata = 16'hDEAD;
    step();
    chk("drained_valid", {15'd0, if_valid}, 16'd0);
    chk("drained_addr",  imem_address, 16'h3000);
    imem_rdata = 16'h3333;
    step();
    chk("tgt_valid", {15'd0, if_valid}, 16'd1);
    chk("tgt_instr", if_instruction, 16'h3333);
    chk("tgt_pc",    if_pc, 16'h3000);

    // Redirect with resp and stall in the same cycle
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h4000; imem_rdata = 16'hBEEF;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("rs_valid", {15'd0, if_valid}, 16'd0);
    chk("rs_read",  {15'd0, imem_read}, 16'd1);
    chk("rs_addr",  imem_address, 16'h4000);

    // PC wrap at 0xFFFE
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    chk("wrap_pre_addr", imem_address, 16'hFFFE);
    imem_rdata = 16'h7777;
    step();
    chk("wrap_pc",    if_pc, 16'hFFFE);
    chk("wrap_pc2",   if_pc_plus2, 16'h0000);
    chk("wrap_instr", if_instruction, 16'h7777);
    chk("wrap_addr",  imem_address, 16'h0000);

    // Reset while in HOLD discards the skid word
    stall = 1'b1; imem_rdata = 16'h5555;
    step();
    chk("h2_read", {15'd0, imem_read}, 16'd0);
    reset = 1'b1; imem_resp = 1'b0;
    step();
    chk("rh_read",  {15'd0, imem_read}, 16'd0);
    chk("rh_valid", {15'd0, if_valid}, 16'd0);
    reset = 1'b0; stall = 1'b0;
    #1;
    chk("rh_read2", {15'd0, imem_read}, 16'd1);
    chk("rh_addr",  imem_address, 16'h0000);
    imem_resp = 1'b1; imem_rdata = 16'h1234;
    step();
    chk("rh_instr", if_instruction, 16'h1234);
    chk("rh_pc",    if_pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
